// File: rtl/ahb_arbiter_if.sv
// ahb_arbiter_if: manager request/lock lines, shared transfer signals and the arbiter's grant outputs
interface ahb_arbiter_if #(
    parameter int NumManagers = 4,
    parameter int burstWidth = 3,
    parameter int IdxWidth = $clog2(NumManagers)
);
    logic [NumManagers-1:0] req;
    logic [NumManagers-1:0] lock;
    logic [2:0] trans;
    logic [burstWidth-1:0] burst;
    logic ready;
    logic [NumManagers-1:0] grant;
    logic [IdxWidth-1:0] owner;
    logic [IdxWidth-1:0] dataOwner;
    logic locked;
    modport master (output req, lock, trans, burst, ready, input grant, owner, dataOwner, locked);
    modport slave (input req, lock, trans, burst, ready, output grant, owner, dataOwner, locked);
endinterface

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB arbiter that hands over only at transfer boundaries and honours locked sequences
module ahb_arbiter #(
    parameter int NumManagers = 4,
    parameter int burstWidth = 3,
    parameter int IdxWidth = $clog2(NumManagers)
) (
    input logic clk,
    input logic reset,
    ahb_arbiter_if.slave bus
);
    typedef enum logic [1:0] {PARK, OWNED, LOCKED} state_t;
    state_t state, state_nxt;
    logic [IdxWidth-1:0] owner, owner_nxt, data_owner, cand;
    logic [3:0] beats_left, beats_nxt, burst_last;
    logic [2:0] burst3;
    logic idle, nonseq, seq, boundary, found;
    always_comb begin
        burst3 = 3'(bus.burst);
        idle = bus.trans[2] || bus.trans == 3'd0;
        nonseq = bus.trans == 3'd2;
        seq = bus.trans == 3'd3;
        burst_last = burst3[2:1] == 2'd0 ? 4'd0 : burst3[2:1] == 2'd1 ? 4'd3 : burst3[2:1] == 2'd2 ? 4'd7 : 4'd15;
        beats_nxt = !bus.ready ? beats_left : nonseq ? burst_last :
                    seq ? (beats_left == 4'd0 ? 4'd0 : beats_left - 4'd1) : beats_left;
        // a fixed burst only yields the bus on the SEQ that carries its last beat
        boundary = bus.ready && (idle || (nonseq && burst3 <= 3'd1) || (seq && (burst3 == 3'd1 || beats_left == 4'd1)));
    end
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cand = '0;
        found = 1'b0;
        if (boundary) begin
            if (bus.lock[owner] && bus.req[owner]) begin
                state_nxt = LOCKED;
            end else begin
                state_nxt = PARK;
                owner_nxt = '0;
                for (int i = 1; i <= NumManagers; i++) begin
                    cand = IdxWidth'((int'(owner) + i) % NumManagers);
                    if (!found && bus.req[cand]) begin
                        found = 1'b1;
                        state_nxt = OWNED;
                        owner_nxt = cand;
                    end
                end
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PARK;
            owner <= '0;
            data_owner <= '0;
            beats_left <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            beats_left <= beats_nxt;
            if (bus.ready) data_owner <= owner;
        end
    end
    assign bus.grant = NumManagers'(1) << owner;
    assign bus.owner = owner;
    assign bus.dataOwner = data_owner;
    assign bus.locked = state == LOCKED;
endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin bus arbiter that shares one AHB address/data path among up to 16 managers. It sits between the managers' request/lock lines and the shared manager-side signals of the common AHB interface. It observes the winning manager's `trans`, `burst` and `mastLock` plus the bus `ready`, and moves ownership only at legal transfer boundaries. It also drives the address-phase and data-phase owner indices used by the manager-side write-data and control muxes.

## Interface

Parameters:
- `NumManagers`, default 4: number of requesting managers, legal range 2..16.
- `burstWidth`, default 3: width of the `burst` encoding.
- `IdxWidth`, default `$clog2(NumManagers)`: width of the owner indices.

Ports:
- `clk` in 1: bus clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in `NumManagers`: per-manager bus request.
- `lock` in `NumManagers`: per-manager locked-sequence request (`mastLock` intent).
- `trans` in 3: transfer type on the shared bus. 0 is IDLE, 1 is BUSY, 2 is NONSEQ, 3 is SEQ; values 4..7 are treated as IDLE.
- `burst` in `burstWidth`: 0 SINGLE, 1 INCR, 2 WRAP4, 3 INCR4, 4 WRAP8, 5 INCR8, 6 WRAP16, 7 INCR16.
- `ready` in 1: bus `ready`; high means the current address phase is accepted.
- `grant` out `NumManagers`: one-hot address-phase grant.
- `owner` out `IdxWidth`: index of the granted manager.
- `dataOwner` out `IdxWidth`: index of the manager owning the current data phase.
- `locked` out 1: the bus is held by a locked sequence.

## Operation

State machine `state` has three states: PARK, OWNED and LOCKED.
- PARK: no request was pending at the last boundary; the grant is parked on manager 0.
- OWNED: a requesting manager holds the bus.
- LOCKED: the owner asserted `lock[owner]` at the last boundary.

Beat counter `beatsLeft` is 0..15:
- On an accepted NONSEQ (`ready`=1, `trans`=2), load burst length minus 1: 0 for SINGLE/INCR, 3 for x4, 7 for x8, 15 for x16.
- On an accepted SEQ, decrement it, saturating at 0.
- BUSY and IDLE leave it unchanged.

A boundary occurs when `ready`=1 and one of these holds:
- `trans` is IDLE or illegal;
- NONSEQ with SINGLE or INCR;
- SEQ with INCR;
- SEQ with `beatsLeft`=1 (last beat of a fixed burst).

A BUSY cycle is never a boundary.

Arbitration at a boundary:
- If `lock[owner]` is high and `req[owner]` is high, keep the owner and enter LOCKED.
- Otherwise search `req` round-robin starting at `owner+1` and wrapping, so the current owner is checked last. The winner becomes the owner and the state becomes OWNED.
- If no `req` bit is set, set owner to 0 and enter PARK.

Outside a boundary, `grant` and `owner` hold, including when `req[owner]` drops mid-burst. A fixed burst is never split.

In LOCKED, arbitration is suppressed at every boundary until a boundary where `lock[owner]` is low; normal round-robin then applies.

`dataOwner` loads `owner` on every cycle with `ready`=1 and holds when `ready`=0.

`locked` is high exactly while the state is LOCKED.

`grant` is always the one-hot decode of `owner`. Exactly one bit is set in every state.

## Timing

- Reset (asynchronous, any cycle, including mid-burst): `grant`=1 (manager 0), `owner`=0, `dataOwner`=0, `locked`=0, state PARK, `beatsLeft`=0.
- Grant latency: a boundary sampled at edge N makes the new `grant`/`owner` visible after edge N. The new manager drives its first address phase in the cycle after edge N.
- Idle-bus request: from PARK with `trans`=IDLE and `ready`=1, a `req` asserted before edge N is granted after edge N (one cycle).
- `ready`=0: no boundary occurs, and all state, `beatsLeft` and `dataOwner` hold.
- A new request and a boundary in the same cycle: the new request takes part in that arbitration.
- Simultaneous drop of `req[owner]` and a boundary: the owner is treated as not requesting.
- After reset is released, the first edge behaves as in PARK.

## Test plan

- Reset then `req`=4'b0100 with `trans`=IDLE and `ready`=1 -> `grant`=4'b0100 and `owner`=2 one cycle later; `dataOwner`=2 one cycle after that.
- Manager 1 issues an INCR4 (NONSEQ, SEQ×3) while `req`=4'b1010 with one `ready`=0 wait state on beat 2 -> `grant` stays 4'b0010 through all four beats. It switches to 4'b1000 only after the edge that accepts the last SEQ.
- Managers 0..3 all requesting continuously with SINGLE transfers -> the grant sequence is 1, 2, 3, 0, 1 (starting from owner 0), one switch per accepted transfer.
- Manager 3 holds `lock` across three SINGLE transfers while managers 0..2 request -> `locked`=1 and `grant`=4'b1000 throughout. When `lock[3]` drops, the next boundary grants manager 0.
- A BUSY cycle inside an INCR8 -> no handover on the BUSY cycle and `beatsLeft` unchanged.
- All requests drop at a boundary -> PARK with `grant`=4'b0001. `reset` asserted mid-WRAP8 -> all outputs return to reset values immediately.
